// File: rtl/msg_scheduler.sv
// msg_scheduler: SHA-2 message schedule generator streaming W[0..ROUNDS-1] from a 16-word sliding window
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_in              begin a new block (abort any block in flight)
//   data_in/valid/ready   load interface, 16 words, W[0] first
//   w_out/w_idx_out       schedule word W[t] and its index t
//   w_valid_out/ready_in  output interface with backpressure
//   done_out              one-cycle pulse after the last word handshake
//   err_out               sticky protocol error when MSG_SCHED_ERR_EN is defined, else tied 0
// Optional feature macro: MSG_SCHED_ERR_EN
module msg_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [6:0]            w_idx_out,
    output logic                  w_valid_out,
    input  logic                  w_ready_in,
    output logic                  done_out,
    output logic                  err_out
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
    state_t state_q;
    logic [15:0][DATA_WIDTH-1:0] win_q;
    logic [3:0] load_cnt_q;
    logic [6:0] t_q;
    logic [DATA_WIDTH-1:0] win15_d;

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] s0(input logic [DATA_WIDTH-1:0] x);
        return (DATA_WIDTH == 64) ? (rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7))
                                  : (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] s1(input logic [DATA_WIDTH-1:0] x);
        return (DATA_WIDTH == 64) ? (rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6))
                                  : (rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10));
    endfunction

    // win[0..15] = W[t..t+15], so the new tail is W[t+16]
    always_comb win15_d = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];

    assign w_out = win_q[0];
    assign w_idx_out = t_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q <= '0;
            load_cnt_q <= '0;
            t_q <= '0;
            data_ready_out <= 1'b0;
            w_valid_out <= 1'b0;
            done_out <= 1'b0;
        end else if (start_in) begin
            state_q <= LOAD;
            load_cnt_q <= '0;
            t_q <= '0;
            data_ready_out <= 1'b1;
            w_valid_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (data_valid_in) begin
                    win_q[load_cnt_q] <= data_in;
                    load_cnt_q <= load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_q <= EXPAND;
                        data_ready_out <= 1'b0;
                        w_valid_out <= 1'b1;
                    end
                end
                EXPAND: if (w_ready_in) begin
                    win_q <= {win15_d, win_q[15:1]};
                    t_q <= t_q + 7'd1;
                    if (t_q == 7'(ROUNDS - 1)) begin
                        state_q <= DONE;
                        w_valid_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MSG_SCHED_ERR_EN
    // a start while LOAD or EXPAND is active aborts a block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_out <= 1'b0;
        else if ((data_valid_in && state_q != LOAD) || (start_in && (state_q == LOAD || state_q == EXPAND)))
            err_out <= 1'b1;
    end
`else
    assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_msg_scheduler.sv
// tb_msg_scheduler: scoreboard bench for msg_scheduler in SHA-256 and SHA-512 configurations
module tb_msg_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

`ifdef MSG_SCHED_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic start32 = 1'b0, dv32 = 1'b0, r32 = 1'b0;
    logic [31:0] d32 = '0;
    logic dr32, v32, done32, err32;
    logic [31:0] w32;
    logic [6:0] idx32;

    logic start64 = 1'b0, dv64 = 1'b0, r64 = 1'b0;
    logic [63:0] d64 = '0;
    logic dr64, v64, done64, err64;
    logic [63:0] w64;
    logic [6:0] idx64;

    msg_scheduler #(.DATA_WIDTH(32), .ROUNDS(64)) dut32 (
        .clk(clk), .rst(rst), .start_in(start32), .data_in(d32), .data_valid_in(dv32),
        .data_ready_out(dr32), .w_out(w32), .w_idx_out(idx32), .w_valid_out(v32),
        .w_ready_in(r32), .done_out(done32), .err_out(err32)
    );

    msg_scheduler #(.DATA_WIDTH(64), .ROUNDS(80)) dut64 (
        .clk(clk), .rst(rst), .start_in(start64), .data_in(d64), .data_valid_in(dv64),
        .data_ready_out(dr64), .w_out(w64), .w_idx_out(idx64), .w_valid_out(v64),
        .w_ready_in(r64), .done_out(done64), .err_out(err64)
    );

    typedef struct packed {
        logic [6:0]  i;
        logic [63:0] w;
    } ent_t;
    typedef logic [63:0] blk_t [16];

    ent_t q32[$];
    ent_t q64[$];
    logic [63:0] wm [96];
    int checks = 0;
    int failures = 0;
    int hs32 = 0;
    int hs64 = 0;
    bit fin32 = 1'b0, fin64 = 1'b0, abc32 = 1'b0, abc64 = 1'b0;
    logic err_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit wide);
        logic [31:0] lo;
        lo = x[31:0];
        return wide ? ((x >> n) | (x << (64 - n))) : {32'h0, (lo >> n) | (lo << (32 - n))};
    endfunction

    function automatic logic [63:0] sg0(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 1, 1) ^ rr(x, 8, 1) ^ (x >> 7)) : (rr(x, 7, 0) ^ rr(x, 18, 0) ^ (x >> 3));
    endfunction

    function automatic logic [63:0] sg1(input logic [63:0] x, input bit wide);
        return wide ? (rr(x, 19, 1) ^ rr(x, 61, 1) ^ (x >> 6)) : (rr(x, 17, 0) ^ rr(x, 19, 0) ^ (x >> 10));
    endfunction

    // reference schedule in the textbook W[t-2], W[t-7], W[t-15], W[t-16] form
    task automatic build(input bit wide, input blk_t b);
        logic [63:0] s;
        for (int t = 0; t < 16; t++) wm[t] = wide ? b[t] : {32'h0, b[t][31:0]};
        for (int t = 16; t < 96; t++) begin
            s = sg1(wm[t-2], wide) + wm[t-7] + sg0(wm[t-15], wide) + wm[t-16];
            wm[t] = wide ? s : {32'h0, s[31:0]};
        end
    endtask

    function automatic logic [63:0] hand32(input logic [6:0] i);
        return (i == 7'd16) ? 64'h61626380 : (i == 7'd17) ? 64'h000F0000 : 64'h7DA86405;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("done32", {63'h0, done32}, {63'h0, fin32});
            fin32 = 1'b0;
            if (v32) begin
                if (q32.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL w32_unexpected actual=%h idx=%0d required=none", w32, idx32);
                end else begin
                    chk("w32_word", {32'h0, w32}, q32[0].w);
                    chk("w32_idx", {57'h0, idx32}, {57'h0, q32[0].i});
                    if (r32) begin
                        if (abc32 && q32[0].i >= 7'd16 && q32[0].i <= 7'd18)
                            chk("w32_abc_hand", {32'h0, w32}, hand32(q32[0].i));
                        fin32 = (q32[0].i == 7'd63);
                        hs32++;
                        void'(q32.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("done64", {63'h0, done64}, {63'h0, fin64});
            fin64 = 1'b0;
            if (v64) begin
                if (q64.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL w64_unexpected actual=%h idx=%0d required=none", w64, idx64);
                end else begin
                    chk("w64_word", w64, q64[0].w);
                    chk("w64_idx", {57'h0, idx64}, {57'h0, q64[0].i});
                    if (r64) begin
                        if (abc64 && q64[0].i == 7'd16)
                            chk("w64_abc_hand", w64, 64'h6162638000000000);
                        fin64 = (q64[0].i == 7'd79);
                        hs64++;
                        void'(q64.pop_front());
                    end
                end
            end
        end
    end

    task automatic load(input bit wide, input blk_t b, input int n);
        build(wide, b);
        @(posedge clk); #1;
        if (wide) start64 = 1'b1; else start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        start64 = 1'b0;
        if (wide) begin
            q64.delete();
            hs64 = 0;
            for (int t = 0; t < 80; t++) q64.push_back('{i: 7'(t), w: wm[t]});
        end else begin
            q32.delete();
            hs32 = 0;
            for (int t = 0; t < 64; t++) q32.push_back('{i: 7'(t), w: wm[t]});
        end
        for (int k = 0; k < n; k++) begin
            if (wide) begin dv64 = 1'b1; d64 = b[k]; end
            else begin dv32 = 1'b1; d32 = b[k][31:0]; end
            @(posedge clk); #1;
        end
        dv32 = 1'b0;
        dv64 = 1'b0;
    endtask

    task automatic run(input bit wide, input bit rnd, input int stop_at);
        logic rdy;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (wide ? done64 : done32) return;
            if (stop_at >= 0 && (wide ? hs64 : hs32) == stop_at) begin
                r32 = 1'b0;
                r64 = 1'b0;
                return;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wide) r64 = rdy; else r32 = rdy;
        end
        checks++;
        failures++;
        $display("FAIL run_timeout actual=no_done required=done");
    endtask

    task automatic chk_reset();
        chk("rst_ready32", {63'h0, dr32}, 64'h0);
        chk("rst_valid32", {63'h0, v32}, 64'h0);
        chk("rst_w32", {32'h0, w32}, 64'h0);
        chk("rst_idx32", {57'h0, idx32}, 64'h0);
        chk("rst_done32", {63'h0, done32}, 64'h0);
        chk("rst_err32", {63'h0, err32}, 64'h0);
        chk("rst_ready64", {63'h0, dr64}, 64'h0);
        chk("rst_valid64", {63'h0, v64}, 64'h0);
        chk("rst_w64", w64, 64'h0);
        chk("rst_done64", {63'h0, done64}, 64'h0);
    endtask

    task automatic post_block(input bit wide, input string tag);
        @(posedge clk); #1;
        if (wide) begin
            chk({tag, "_left64"}, 64'(q64.size()), 64'h0);
            chk({tag, "_tail64"}, w64, wm[80]);
            chk({tag, "_valid64"}, {63'h0, v64}, 64'h0);
            chk({tag, "_err64"}, {63'h0, err64}, 64'h0);
        end else begin
            chk({tag, "_left32"}, 64'(q32.size()), 64'h0);
            chk({tag, "_tail32"}, {32'h0, w32}, wm[64]);
            chk({tag, "_valid32"}, {63'h0, v32}, 64'h0);
            chk({tag, "_ready32"}, {63'h0, dr32}, 64'h0);
            chk({tag, "_err32"}, {63'h0, err32}, {63'h0, err_exp});
        end
    endtask

    initial begin
        blk_t abc;
        blk_t abcw;
        blk_t bb;
        for (int k = 0; k < 16; k++) begin
            abc[k] = 64'h0;
            abcw[k] = 64'h0;
            bb[k] = {32'h0, (32'h9E3779B9 * 32'(k + 1)) ^ 32'h0F1E2D3C};
        end
        abc[0] = 64'h61626380;
        abc[15] = 64'h18;
        abcw[0] = 64'h6162638000000000;
        abcw[15] = 64'h18;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_reset();
        rst = 1'b0;

        // "abc" with the core always ready
        abc32 = 1'b1;
        load(0, abc, 16);
        chk("w_valid_after_load", {63'h0, v32}, 64'h1);
        run(0, 0, -1);
        post_block(0, "abc_ready");

        // "abc" with random backpressure
        load(0, abc, 16);
        run(0, 1, -1);
        post_block(0, "abc_stall");

        // abort at t=30, restart with a different block
        load(0, abc, 16);
        run(0, 1, 30);
        abc32 = 1'b0;
        load(0, bb, 16);
        err_exp = ERR_ON;
        chk("abort_err", {63'h0, err32}, {63'h0, err_exp});
        run(0, 1, -1);
        post_block(0, "restart");

        // reset after 7 load words, then a full block
        load(0, bb, 7);
        rst = 1'b1;
        q32.delete();
        #1 chk_reset();
        err_exp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        load(0, bb, 16);
        run(0, 1, -1);
        post_block(0, "after_rst");

        // data_valid while idle must not touch the window
        dv32 = 1'b1;
        d32 = 32'hDEADBEEF;
        @(posedge clk); #1;
        dv32 = 1'b0;
        err_exp = ERR_ON;
        chk("idle_err", {63'h0, err32}, {63'h0, err_exp});
        chk("idle_w", {32'h0, w32}, wm[64]);
        chk("idle_ready", {63'h0, dr32}, 64'h0);
        @(posedge clk); #1;
        chk("idle_w2", {32'h0, w32}, wm[64]);

        // SHA-512 "abc", 80 rounds
        abc64 = 1'b1;
        load(1, abcw, 16);
        run(1, 1, -1);
        post_block(1, "sha512");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
